// File: rtl/image_filter_3x3_if.sv
// Source-ROM read port, frame-buffer write port and start/done handshake of the 3x3 filter.
// Latency: none (wires only); src_data is expected one cycle after src_addr.
// Backpressure: none; the filter never stalls, so there are no ready signals.
interface image_filter_3x3_if #(
  parameter int ADDR_W = 19
);
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] src_addr;
  logic [7:0]        src_data;
  logic              dst_we;
  logic [ADDR_W-1:0] dst_addr;
  logic [7:0]        dst_data;
  logic              busy;
  logic              done;

  // Filter side.
  modport master (
    input  start, mode, src_data,
    output src_addr, dst_we, dst_addr, dst_data, busy, done
  );

  // Environment side (ROM, frame buffer, controller).
  modport slave (
    output start, mode, src_data,
    input  src_addr, dst_we, dst_addr, dst_data, busy, done
  );
endinterface

// File: rtl/image_filter_3x3.sv
// Streaming 3x3 filter: clears the frame buffer, then filters a ROM image in raster order into it.
// Latency: src_addr A in cycle t -> write for centre A-(WIDTH+1) in t+3; done one cycle after last write.
// Backpressure: none; one read and at most one write per cycle, never stalls.
module image_filter_3x3 #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19
) (
  input  logic               clk,
  input  logic               reset,
  image_filter_3x3_if.master bus
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int XW   = (WIDTH  > 2) ? $clog2(WIDTH)  : 2;
  localparam int YW   = (HEIGHT > 2) ? $clog2(HEIGHT) : 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Shared linear counter: clear address in CLEAR, read address in RUN.
  logic [ADDR_W-1:0] cnt;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [1:0]        flush_cnt;
  logic [1:0]        mode_q;

  logic cnt_last;
  logic x_last;
  assign cnt_last = (cnt == ADDR_W'(NPIX - 1));
  assign x_last   = (x == XW'(WIDTH - 1));

  // Stage 1: the read issued last cycle; src_data belongs to it.
  logic              rd_vld;
  logic [XW-1:0]     rd_x;
  logic [YW-1:0]     rd_y;
  logic [ADDR_W-1:0] rd_addr;

  // Stage 2: the window now holds the neighbourhood of this read position.
  logic              s2_vld;
  logic [XW-1:0]     s2_x;
  logic [YW-1:0]     s2_y;
  logic [ADDR_W-1:0] s2_addr;

  // Stage 3: registered kernel result, driven onto the write port.
  logic              out_vld;
  logic [ADDR_W-1:0] out_addr;
  logic [7:0]        out_data;

  // Line buffers hold rows y-1 (lb1) and y-2 (lb2); win[row][col], row 2 / col 2 newest.
  logic [7:0] lb1 [0:WIDTH-1];
  logic [7:0] lb2 [0:WIDTH-1];
  logic [7:0] win [0:2][0:2];

  logic [11:0]        c12, nsew, diag, blur_sum;
  logic signed [13:0] sharp_s, edge_s;
  logic [7:0]         kern;

  function automatic logic [7:0] clamp8(input logic signed [13:0] v);
    if (v < 14'sd0)
      return 8'd0;
    else if (v > 14'sd255)
      return 8'hFF;
    else
      return v[7:0];
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state: start is only looked at in IDLE; FLUSH covers the three pipeline stages.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_CLEAR;
      S_CLEAR: if (cnt_last) state_nxt = S_RUN;
      S_RUN:   if (cnt_last) state_nxt = S_FLUSH;
      S_FLUSH: if (flush_cnt == 2'd2) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address / column / row counters, flush timer and kernel select latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      x         <= '0;
      y         <= '0;
      flush_cnt <= '0;
      mode_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt       <= '0;
          x         <= '0;
          y         <= '0;
          flush_cnt <= '0;
          if (bus.start) mode_q <= bus.mode;
        end
        S_CLEAR: begin
          cnt <= cnt_last ? '0 : cnt + ADDR_W'(1);
        end
        S_RUN: begin
          cnt       <= cnt_last ? '0 : cnt + ADDR_W'(1);
          flush_cnt <= '0;
          if (x_last) begin
            x <= '0;
            y <= cnt_last ? '0 : y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end
        S_FLUSH: begin
          flush_cnt <= flush_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Pipeline valid/position tracking; cleared on reset so an abort emits no stray writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld  <= 1'b0;
      rd_x    <= '0;
      rd_y    <= '0;
      rd_addr <= '0;
      s2_vld  <= 1'b0;
      s2_x    <= '0;
      s2_y    <= '0;
      s2_addr <= '0;
    end else begin
      rd_vld  <= (state == S_RUN);
      rd_x    <= x;
      rd_y    <= y;
      rd_addr <= cnt;
      s2_vld  <= rd_vld;
      s2_x    <= rd_x;
      s2_y    <= rd_y;
      s2_addr <= rd_addr;
    end
  end

  // Shift the returned pixel into the window and rotate the column through both line buffers.
  always_ff @(posedge clk) begin
    if (rd_vld) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2]  <= lb2[rd_x];
      win[1][2]  <= lb1[rd_x];
      win[2][2]  <= bus.src_data;
      lb2[rd_x]  <= lb1[rd_x];
      lb1[rd_x]  <= bus.src_data;
    end
  end

  // Kernel arithmetic on the centre, edge neighbours and diagonals of the window.
  always_comb begin
    c12      = {4'b0, win[1][1]};
    nsew     = {4'b0, win[0][1]} + {4'b0, win[2][1]} + {4'b0, win[1][0]} + {4'b0, win[1][2]};
    diag     = {4'b0, win[0][0]} + {4'b0, win[0][2]} + {4'b0, win[2][0]} + {4'b0, win[2][2]};
    blur_sum = (c12 << 2) + (nsew << 1) + diag;
    sharp_s  = $signed({2'b00, (c12 << 2) + c12}) - $signed({2'b00, nsew});
    edge_s   = $signed({2'b00, c12 << 3}) - $signed({2'b00, nsew + diag});
    case (mode_q)
      2'b00:   kern = win[1][1];
      2'b01:   kern = blur_sum[11:4];
      2'b10:   kern = clamp8(sharp_s);
      default: kern = clamp8(edge_s);
    endcase
  end

  // Register the result; rows/columns 0 and 1 of the read scan hold wrapped, stale windows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld  <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      out_vld  <= s2_vld && (s2_x >= XW'(2)) && (s2_y >= YW'(2));
      out_addr <= s2_addr - ADDR_W'(WIDTH + 1);
      out_data <= kern;
    end
  end

  // Outputs: clear writes in CLEAR, filtered writes from the pipeline, status from the state.
  always_comb begin
    bus.src_addr = '0;
    bus.dst_we   = 1'b0;
    bus.dst_addr = '0;
    bus.dst_data = '0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state)
      S_CLEAR: begin
        bus.dst_we   = 1'b1;
        bus.dst_addr = cnt;
        bus.busy     = 1'b1;
      end
      S_RUN: begin
        bus.src_addr = cnt;
        bus.busy     = 1'b1;
      end
      S_FLUSH: bus.busy = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
    if (out_vld) begin
      bus.dst_we   = 1'b1;
      bus.dst_addr = out_addr;
      bus.dst_data = out_data;
    end
  end

endmodule
